// File: rtl/cpu_sdram_ctrl.sv
// cpu_sdram_ctrl: closed-page single-word controller for the 16-bit zs_* SDRAM bus.
// Periodic auto-refresh is built only when CPU_SDRAM_CTRL_AUTOREFRESH_EN is defined.
module cpu_sdram_ctrl #(
  parameter int CAS_LATENCY = 3,
  parameter int T_INIT = 2000,
  parameter int T_RP = 2,
  parameter int T_RCD = 2,
  parameter int T_RFC = 7,
  parameter int T_MRD = 2,
  parameter int T_WR = 2,
  parameter int T_REF = 781
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [24:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic [1:0]  req_be,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        init_done,
  output logic [12:0] zs_addr,
  output logic [1:0]  zs_ba,
  output logic        zs_cs_n,
  output logic        zs_ras_n,
  output logic        zs_cas_n,
  output logic        zs_we_n,
  output logic        zs_cke,
  output logic [1:0]  zs_dqm,
  inout  wire  [15:0] zs_dq
);
  localparam int W = $clog2((T_INIT > T_REF ? T_INIT : T_REF) + 1);
  localparam logic [2:0] C_LMR = 3'b000, C_ARF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011;
  localparam logic [2:0] C_WR = 3'b100, C_RD = 3'b101, C_NOP = 3'b111;
  typedef enum logic [3:0] {
    INIT_WAIT, INIT_PRE, INIT_REF1, INIT_REF2, INIT_LMR, IDLE, REFRESH,
    ACTIVATE, READ, READ_WAIT, WRITE, PRECHARGE
  } state_t;
  state_t state;
  logic [W-1:0] cnt;
  logic [2:0] cmd;
  logic wr_q;
  logic [9:0] col_q;
  logic [1:0] be_q;
  logic [15:0] dq_out;
  logic dq_oe;
  logic zero, ref_due, ref_go, accept;
  assign zero = cnt == '0;
  assign req_ready = state == IDLE && init_done && !ref_due;
  assign accept = req_valid && req_ready;
  assign ref_go = state == IDLE && init_done && ref_due;
  assign {zs_ras_n, zs_cas_n, zs_we_n} = cmd;
  assign zs_cke = 1'b1;
  assign zs_dq = dq_oe ? dq_out : {16{1'bz}};
`ifdef CPU_SDRAM_CTRL_AUTOREFRESH_EN
  logic [W-1:0] ref_cnt;
  logic refresh_pending;
  assign ref_due = refresh_pending;
  // a second expiry while still pending just re-sets the same flag
  always_ff @(posedge clk)
    if (reset) begin
      ref_cnt <= W'(T_REF);
      refresh_pending <= 1'b0;
    end else if (init_done) begin
      ref_cnt <= ref_cnt == W'(1) ? W'(T_REF) : ref_cnt - W'(1);
      refresh_pending <= ref_cnt == W'(1) || (refresh_pending && !ref_go);
    end
`else
  assign ref_due = 1'b0;
`endif
  always_ff @(posedge clk)
    if (reset) begin
      state <= INIT_WAIT;
      cnt <= W'(T_INIT - 1);
      cmd <= C_NOP;
      zs_cs_n <= 1'b1;
      zs_addr <= '0;
      zs_ba <= '0;
      zs_dqm <= 2'b11;
      dq_oe <= 1'b0;
      dq_out <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      init_done <= 1'b0;
      wr_q <= 1'b0;
      col_q <= '0;
      be_q <= '0;
    end else begin
      zs_cs_n <= 1'b0;
      cmd <= C_NOP;
      zs_dqm <= 2'b11;
      dq_oe <= 1'b0;
      rsp_valid <= 1'b0;
      cnt <= zero ? cnt : cnt - W'(1);
      case (state)
        INIT_WAIT: if (zero) begin
          cmd <= C_PRE;
          zs_addr <= 13'h0400;
          cnt <= W'(T_RP - 1);
          state <= INIT_PRE;
        end
        INIT_PRE: if (zero) begin
          cmd <= C_ARF;
          cnt <= W'(T_RFC - 1);
          state <= INIT_REF1;
        end
        INIT_REF1: if (zero) begin
          cmd <= C_ARF;
          cnt <= W'(T_RFC - 1);
          state <= INIT_REF2;
        end
        INIT_REF2: if (zero) begin
          cmd <= C_LMR;
          zs_ba <= 2'b00;
          zs_addr <= {6'b0, 3'(CAS_LATENCY), 4'b0000};
          cnt <= W'(T_MRD - 1);
          state <= INIT_LMR;
        end
        INIT_LMR: if (zero) begin
          init_done <= 1'b1;
          state <= IDLE;
        end
        IDLE: if (ref_go) begin
          cmd <= C_ARF;
          cnt <= W'(T_RFC - 1);
          state <= REFRESH;
        end else if (accept) begin
          cmd <= C_ACT;
          zs_ba <= {req_addr[24], req_addr[10]};
          zs_addr <= req_addr[23:11];
          wr_q <= req_wr;
          col_q <= req_addr[9:0];
          be_q <= req_be;
          dq_out <= req_wdata;
          cnt <= W'(T_RCD - 1);
          state <= ACTIVATE;
        end
        REFRESH: if (zero) state <= IDLE;
        ACTIVATE: if (zero) begin
          cmd <= wr_q ? C_WR : C_RD;
          zs_addr <= {3'b000, col_q};
          zs_dqm <= wr_q ? ~be_q : 2'b00;
          dq_oe <= wr_q;
          cnt <= W'(T_WR - 1);
          state <= wr_q ? WRITE : READ;
        end
        // READ marks the cycle the device samples RD; the CAS count starts after it
        READ: begin
          cnt <= W'(CAS_LATENCY - 1);
          state <= READ_WAIT;
        end
        READ_WAIT: if (zero) begin
          rsp_valid <= 1'b1;
          rsp_rdata <= zs_dq;
          cmd <= C_PRE;
          zs_addr <= 13'h0400;
          cnt <= W'(T_RP - 1);
          state <= PRECHARGE;
        end
        WRITE: if (zero) begin
          cmd <= C_PRE;
          zs_addr <= 13'h0400;
          cnt <= W'(T_RP - 1);
          state <= PRECHARGE;
        end
        PRECHARGE: if (zero) state <= IDLE;
        default: state <= INIT_WAIT;
      endcase
    end
endmodule

// File: tb/tb_cpu_sdram_ctrl.sv
// tb_cpu_sdram_ctrl: random host traffic against a behavioural SDRAM device, checked by a
// host-side memory scoreboard plus init, decode, byte-mask, refresh and reset checks.
module tb_cpu_sdram_ctrl;
  localparam int CL = 3, TI = 20, TRP = 2, TRCD = 2, TRFC = 7, TMRD = 2, TWR = 2, TREF = 50;
  logic clk = 1'b0, reset = 1'b1, req_valid = 1'b0, req_wr = 1'b0;
  logic [24:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [1:0] req_be = '0;
  logic req_ready, rsp_valid, init_done, zs_cs_n, zs_ras_n, zs_cas_n, zs_we_n, zs_cke;
  logic [15:0] rsp_rdata;
  logic [12:0] zs_addr;
  logic [1:0] zs_ba, zs_dqm;
  wire [15:0] zs_dq;
  logic dev_oe = 1'b0;
  logic [15:0] dev_dq = '0;
  assign zs_dq = dev_oe ? dev_dq : 16'hzzzz;

  typedef struct { bit [15:0] d; int acc; } exp_t;
  typedef struct { bit [24:0] a; bit [15:0] d; bit [1:0] dqm; } wr_t;
  typedef struct { int t; bit [15:0] d; } rdp_t;
  exp_t exp_q[$];
  wr_t wr_chk_q[$];
  bit [24:0] rd_chk_q[$];
  rdp_t rd_pipe[$];
  int arf_t[$];
  bit [15:0] ref_mem [bit [24:0]];
  bit [15:0] dev_mem [bit [24:0]];
  bit [12:0] open_row [4];
  bit [1:0] last_act_ba, last_rd_ba, last_wr_dqm;
  bit [12:0] last_act_addr, last_rd_addr;
  int errors = 0, checks = 0, cyc = 0, last_acc = 0, wr_cyc = -1;
  exp_t mon_e;
  wr_t dm_w;
  bit [24:0] dm_a;
  bit [2:0] dm_c;
  bit [15:0] dm_m, dm_old;

  cpu_sdram_ctrl #(.CAS_LATENCY(CL), .T_INIT(TI), .T_RP(TRP), .T_RCD(TRCD), .T_RFC(TRFC),
    .T_MRD(TMRD), .T_WR(TWR), .T_REF(TREF)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .init_done(init_done), .zs_addr(zs_addr), .zs_ba(zs_ba),
    .zs_cs_n(zs_cs_n), .zs_ras_n(zs_ras_n), .zs_cas_n(zs_cas_n), .zs_we_n(zs_we_n),
    .zs_cke(zs_cke), .zs_dqm(zs_dqm), .zs_dq(zs_dq));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit is_cmd(input bit [2:0] c);
    return !zs_cs_n && {zs_ras_n, zs_cas_n, zs_we_n} == c;
  endfunction

  task automatic check_reset();
    chk("rst_cmd", {zs_cs_n, zs_ras_n, zs_cas_n, zs_we_n}, 4'hF);
    chk("rst_cke", zs_cke, 1);
    chk("rst_addr", zs_addr, 0);
    chk("rst_ba", zs_ba, 0);
    chk("rst_dqm", zs_dqm, 3);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_init_done", init_done, 0);
  endtask

  // called on a negedge after at least one reset edge; walks the whole power-up sequence
  task automatic init_seq();
    int pre_k, arf1, arf2, lmr, done_k, c, e;
    pre_k = TI + 1;
    arf1 = pre_k + TRP;
    arf2 = arf1 + TRFC;
    lmr = arf2 + TRFC;
    done_k = lmr + TMRD;
    reset = 1'b0;
    for (int k = 1; k <= done_k + 1; k++) begin
      c = zs_cs_n ? 7 : int'({zs_ras_n, zs_cas_n, zs_we_n});
      e = k == pre_k ? 2 : (k == arf1 || k == arf2) ? 1 : k == lmr ? 0 : 7;
      if (k == 1) check_reset();
      chk("init_cmd", c, e);
      chk("init_done", init_done, int'(k >= done_k));
      if (k == pre_k) chk("init_pre_addr", zs_addr, 13'h400);
      if (k == lmr) begin
        chk("lmr_addr", zs_addr, 13'h030);
        chk("lmr_ba", zs_ba, 0);
      end
      @(negedge clk);
    end
  endtask

  // called on a negedge; returns on the negedge after the accept edge
  task automatic do_req(input bit wr, input bit [24:0] a, input bit [15:0] d, input bit [1:0] be);
    int n;
    bit [15:0] m, old;
    n = 0;
    req_valid = 1'b1;
    req_wr = wr;
    req_addr = a;
    req_wdata = d;
    req_be = be;
    while (!req_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", int'(req_ready), 1);
    if (!req_ready) begin
      req_valid = 1'b0;
      return;
    end
    last_acc = cyc + 1;
    old = ref_mem.exists(a) ? ref_mem[a] : 16'h0;
    if (wr) begin
      m = {{8{be[1]}}, {8{be[0]}}};
      ref_mem[a] = (old & ~m) | (d & m);
      wr_chk_q.push_back('{a, d, ~be});
    end else begin
      exp_q.push_back('{old, cyc + 1});
      rd_chk_q.push_back(a);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  always @(negedge clk)
    if (rsp_valid) begin
      if (exp_q.size() == 0) chk("unexpected_rsp", 1, 0);
      else begin
        mon_e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, mon_e.d);
        chk("rsp_latency", cyc - mon_e.acc, 1 + TRCD + CL);
      end
    end

  // behavioural SDRAM: commands seen here are sampled by the device at the next rising edge
  always @(negedge clk) begin
    dev_oe = 1'b0;
    if (rd_pipe.size() > 0 && rd_pipe[0].t == cyc) begin
      dev_dq = rd_pipe[0].d;
      dev_oe = 1'b1;
      void'(rd_pipe.pop_front());
    end
    dm_c = zs_cs_n ? 3'b111 : {zs_ras_n, zs_cas_n, zs_we_n};
    dm_a = {zs_ba[1], open_row[zs_ba], zs_ba[0], zs_addr[9:0]};
    if (dm_c != 3'b101 && dm_c != 3'b100) chk("dqm_idle", zs_dqm, 3);
    case (dm_c)
      3'b011: begin
        open_row[zs_ba] = zs_addr;
        last_act_ba = zs_ba;
        last_act_addr = zs_addr;
      end
      3'b101: begin
        chk("rd_a10", zs_addr[10], 0);
        chk("rd_dqm", zs_dqm, 0);
        last_rd_ba = zs_ba;
        last_rd_addr = zs_addr;
        if (rd_chk_q.size() > 0) chk("rd_addr_map", dm_a, rd_chk_q.pop_front());
        else chk("unexpected_rd", 1, 0);
        rd_pipe.push_back('{cyc + CL, dev_mem.exists(dm_a) ? dev_mem[dm_a] : 16'h0});
      end
      3'b100: begin
        chk("wr_a10", zs_addr[10], 0);
        if (wr_chk_q.size() > 0) begin
          dm_w = wr_chk_q.pop_front();
          chk("wr_addr_map", dm_a, dm_w.a);
          chk("wr_data", zs_dq, dm_w.d);
          chk("wr_dqm", zs_dqm, dm_w.dqm);
        end else chk("unexpected_wr", 1, 0);
        dm_m = {{8{~zs_dqm[1]}}, {8{~zs_dqm[0]}}};
        dm_old = dev_mem.exists(dm_a) ? dev_mem[dm_a] : 16'h0;
        dev_mem[dm_a] = (dm_old & ~dm_m) | (zs_dq & dm_m);
        last_wr_dqm = zs_dqm;
        wr_cyc = cyc;
      end
      3'b010: begin
        chk("pre_a10", zs_addr[10], 1);
        if (wr_cyc >= 0) chk("t_wr", int'(cyc - wr_cyc >= TWR), 1);
        wr_cyc = -1;
      end
      3'b001: begin
`ifdef CPU_SDRAM_CTRL_AUTOREFRESH_EN
        if (init_done) arf_t.push_back(cyc);
`else
        chk("no_arf_after_init", init_done, 0);
`endif
      end
      default: ;
    endcase
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, a_cyc;
    bit [24:0] pool [8];
    pool[0] = 25'h0000000;
    pool[1] = 25'h1FFFFFF;
    pool[2] = 25'h0ABCDEF;
    pool[3] = 25'h1800555;
    for (int i = 4; i < 8; i++) pool[i] = 25'($urandom);
    repeat (3) @(negedge clk);
    init_seq();

    do_req(1, 25'h0ABCDEF, 16'hA5C3, 2'b11);
    do_req(0, 25'h0ABCDEF, 16'h0, 2'b00);

    do_req(1, 25'h0155AA3, 16'h1234, 2'b11);
    do_req(1, 25'h0155AA3, 16'hAB00, 2'b10);
    do_req(0, 25'h0155AA3, 16'h0, 2'b00);
    chk("bytemask_dqm", last_wr_dqm, 2'b01);

    do_req(0, 25'h1800555, 16'h0, 2'b00);
    repeat (3) @(negedge clk);
    chk("dec_act_ba", last_act_ba, 2'b11);
    chk("dec_act_addr", last_act_addr, 13'h1000);
    chk("dec_rd_ba", last_rd_ba, 2'b11);
    chk("dec_rd_addr", last_rd_addr, 13'h0155);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      do_req(1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], 16'($urandom),
             2'($urandom_range(0, 3)));
    end

`ifdef CPU_SDRAM_CTRL_AUTOREFRESH_EN
    repeat (60) @(negedge clk);
    arf_t.delete();
    repeat (3 * TREF + 20) @(negedge clk);
    chk("arf_count", int'(arf_t.size() >= 3), 1);
    for (int i = 1; i < arf_t.size(); i++) chk("arf_interval", arf_t[i] - arf_t[i-1], TREF);
    n = 0;
    while (!is_cmd(3'b001) && n < 2 * TREF) begin
      @(negedge clk);
      n++;
    end
    chk("arf_seen", int'(n < 2 * TREF), 1);
    a_cyc = cyc;
    do_req(0, pool[2], 16'h0, 2'b00);
    chk("req_after_arf", last_acc - a_cyc, TRFC + 1);
`endif

    @(negedge clk);
    do_req(0, 25'h0ABCDEF, 16'h0, 2'b00);
    n = 0;
    while (!is_cmd(3'b101) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rd_before_reset", int'(n < 20), 1);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_reset();
    repeat (4) begin
      @(negedge clk);
      chk("no_rsp_in_reset", rsp_valid, 0);
    end
    init_seq();
    do_req(1, 25'h0F0F0F0, 16'h5AA5, 2'b01);
    do_req(0, 25'h0F0F0F0, 16'h0, 2'b00);
    do_req(0, 25'h0ABCDEF, 16'h0, 2'b00);

    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
